// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared NN datapath defaults, loader state encoding and row geometry helper
package nn_pkg;

    localparam int NN_DATA_WIDTH     = 8;
    localparam int NN_DMA_DATA_WIDTH = 16;
    localparam int NN_ROW_NUM        = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } loader_state_e;

    function automatic int nn_words_per_row(input int row_w, input int dma_w);
        return row_w / dma_w;
    endfunction

endpackage

// File: rtl/nn_row_packer.sv
// rtl/nn_row_packer.sv - packs returning DMA words LSB-first into rows and holds each row
// in an output register until the image buffer accepts it
module nn_row_packer #(
    parameter int DMA_DATA_WIDTH = 16,
    parameter int WORDS_PER_ROW  = 3,
    parameter int ROW_DATA_WIDTH = DMA_DATA_WIDTH * WORDS_PER_ROW
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_word_vld,
    input  logic [DMA_DATA_WIDTH-1:0] i_word,
    input  logic                      i_full,
    output logic                      o_wr_en,
    output logic [ROW_DATA_WIDTH-1:0] o_wr_data,
    output logic                      o_accept
);

    localparam int WC_W = $clog2(WORDS_PER_ROW);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS_PER_ROW - 1);

    logic [WC_W-1:0]           word_cnt_q, word_cnt_d;
    logic [ROW_DATA_WIDTH-1:0] pack_q, pack_d;
    logic [ROW_DATA_WIDTH-1:0] row_q, row_d;
    logic                      wr_en_q, wr_en_d;
    logic [ROW_DATA_WIDTH-1:0] row_merged;

    assign o_accept  = wr_en_q && !i_full;
    assign o_wr_en   = wr_en_q;
    assign o_wr_data = row_q;

    always_comb begin
        word_cnt_d = word_cnt_q;
        pack_d     = pack_q;
        row_d      = row_q;
        wr_en_d    = wr_en_q;
        row_merged = pack_q;
        for (int k = 0; k < WORDS_PER_ROW; k++) begin
            if (word_cnt_q == WC_W'(k)) begin
                row_merged[k*DMA_DATA_WIDTH +: DMA_DATA_WIDTH] = i_word;
            end
        end
        if (o_accept) begin
            wr_en_d = 1'b0;
        end
        // The issue stall upstream guarantees the holding register is free (or
        // being accepted this cycle) whenever the last word of a row lands.
        if (i_word_vld) begin
            pack_d = row_merged;
            if (word_cnt_q == LAST_WORD) begin
                word_cnt_d = '0;
                row_d      = row_merged;
                wr_en_d    = 1'b1;
            end else begin
                word_cnt_d = word_cnt_q + WC_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            word_cnt_q <= '0;
            pack_q     <= '0;
            row_q      <= '0;
            wr_en_q    <= 1'b0;
        end else begin
            word_cnt_q <= word_cnt_d;
            pack_q     <= pack_d;
            row_q      <= row_d;
            wr_en_q    <= wr_en_d;
        end
    end

endmodule

// File: rtl/nn_dma_img_loader.sv
// rtl/nn_dma_img_loader.sv - DMA-to-image-buffer row loader: FSM, DMA/row address counters;
// NN_LOADER_PERF_EN adds the o_stall_cnt backpressure counter
module nn_dma_img_loader
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH      = NN_DATA_WIDTH,
    parameter int ROW_NUM         = NN_ROW_NUM,
    parameter int DMA_DATA_WIDTH  = NN_DMA_DATA_WIDTH,
    parameter int DMA_ADDR_WIDTH  = 10,
    parameter int IMEM_ADDR_WIDTH = 10,
    parameter int ROW_CNT_WIDTH   = 10,
    parameter int ROW_DATA_WIDTH  = DATA_WIDTH * ROW_NUM,
    parameter int WORDS_PER_ROW   = nn_words_per_row(ROW_DATA_WIDTH, DMA_DATA_WIDTH)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic [DMA_ADDR_WIDTH-1:0]  i_dma_base,
    input  logic [IMEM_ADDR_WIDTH-1:0] i_imem_base,
    input  logic [ROW_CNT_WIDTH-1:0]   i_row_cnt,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_dma_rd_en,
    output logic [DMA_ADDR_WIDTH-1:0]  o_dma_rd_addr,
    input  logic [DMA_DATA_WIDTH-1:0]  i_dma_rd_data,
    output logic                       o_img_bf_wr_en,
    output logic [IMEM_ADDR_WIDTH-1:0] o_img_bf_wr_addr,
    output logic [ROW_DATA_WIDTH-1:0]  o_img_bf_wr_data,
    input  logic                       i_img_bf_full
`ifdef NN_LOADER_PERF_EN
    ,
    output logic [15:0]                o_stall_cnt
`endif
);

    if ((WORDS_PER_ROW * DMA_DATA_WIDTH != ROW_DATA_WIDTH) || (WORDS_PER_ROW < 2)) begin : g_bad_geometry
        $error("nn_dma_img_loader: row width must be an exact multiple (>=2) of the DMA word width");
    end

    localparam int WIDX_W = $clog2(WORDS_PER_ROW);
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS_PER_ROW - 1);
    localparam logic [ROW_CNT_WIDTH-1:0] ONE_ROW = ROW_CNT_WIDTH'(1);

    loader_state_e              state_q, state_d;
    logic [DMA_ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [IMEM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [WIDX_W-1:0]          word_idx_q, word_idx_d;
    logic [ROW_CNT_WIDTH-1:0]   rows_issue_q, rows_issue_d;
    logic [ROW_CNT_WIDTH-1:0]   rows_acc_q, rows_acc_d;
    logic                       in_flight_q;
    logic                       rd_en;
    logic                       wr_accept;
    logic                       stall;

    assign stall            = o_img_bf_wr_en && i_img_bf_full;
    assign o_busy           = (state_q == FETCH) || (state_q == DRAIN);
    assign o_done           = (state_q == DONE);
    assign o_dma_rd_en      = rd_en;
    assign o_dma_rd_addr    = rd_addr_q;
    assign o_img_bf_wr_addr = wr_addr_q;

    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        word_idx_d   = word_idx_q;
        rows_issue_d = rows_issue_q;
        rows_acc_d   = rows_acc_q;
        rd_en        = 1'b0;

        if (wr_accept) begin
            wr_addr_d  = wr_addr_q + IMEM_ADDR_WIDTH'(1);
            rows_acc_d = rows_acc_q - ONE_ROW;
        end

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    rd_addr_d    = i_dma_base;
                    wr_addr_d    = i_imem_base;
                    word_idx_d   = '0;
                    rows_issue_d = i_row_cnt;
                    rows_acc_d   = i_row_cnt;
                    state_d      = (i_row_cnt == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                // Holding off issue while the output row is blocked bounds the
                // next row's progress to what the pack register can absorb.
                if (!stall) begin
                    rd_en     = 1'b1;
                    rd_addr_d = rd_addr_q + DMA_ADDR_WIDTH'(1);
                    if (word_idx_q == LAST_WORD) begin
                        word_idx_d   = '0;
                        rows_issue_d = rows_issue_q - ONE_ROW;
                        if (rows_issue_q == ONE_ROW) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        word_idx_d = word_idx_q + WIDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (wr_accept && (rows_acc_q == ONE_ROW)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            word_idx_q   <= '0;
            rows_issue_q <= '0;
            rows_acc_q   <= '0;
            in_flight_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            word_idx_q   <= word_idx_d;
            rows_issue_q <= rows_issue_d;
            rows_acc_q   <= rows_acc_d;
            in_flight_q  <= rd_en;
        end
    end

    nn_row_packer #(
        .DMA_DATA_WIDTH (DMA_DATA_WIDTH),
        .WORDS_PER_ROW  (WORDS_PER_ROW),
        .ROW_DATA_WIDTH (ROW_DATA_WIDTH)
    ) u_packer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_word_vld (in_flight_q),
        .i_word     (i_dma_rd_data),
        .i_full     (i_img_bf_full),
        .o_wr_en    (o_img_bf_wr_en),
        .o_wr_data  (o_img_bf_wr_data),
        .o_accept   (wr_accept)
    );

`ifdef NN_LOADER_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && i_start) begin
            stall_cnt_d = '0;
        end else if (o_busy && stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_nn_dma_img_loader.sv
// tb/tb_nn_dma_img_loader.sv - self-checking bench for nn_dma_img_loader against a row-level memory model
module tb_nn_dma_img_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  dma_base = '0;
    logic [9:0]  imem_base = '0;
    logic [9:0]  row_cnt = '0;
    logic        busy, done, rd_en, wr_en;
    logic [9:0]  rd_addr, wr_addr;
    logic [15:0] rd_data = '0;
    logic [47:0] wr_data;
    logic        full = 1'b0;
`ifdef NN_LOADER_PERF_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    nn_dma_img_loader dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .i_dma_base       (dma_base),
        .i_imem_base      (imem_base),
        .i_row_cnt        (row_cnt),
        .o_busy           (busy),
        .o_done           (done),
        .o_dma_rd_en      (rd_en),
        .o_dma_rd_addr    (rd_addr),
        .i_dma_rd_data    (rd_data),
        .o_img_bf_wr_en   (wr_en),
        .o_img_bf_wr_addr (wr_addr),
        .o_img_bf_wr_data (wr_data),
        .i_img_bf_full    (full)
`ifdef NN_LOADER_PERF_EN
        ,
        .o_stall_cnt      (stall_cnt)
`endif
    );

    logic [15:0] mem [1024];

    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 16'hDEAD;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [9:0]  m_db, m_ib;
    int          m_rc;
    int          rd_idx, wr_idx, start_cyc, first_rd, last_rd, done_rel, rel;
    bit          done_seen, mon_en;
    int          acc_rel[$];
    logic [9:0]  last_acc_addr;
    bit          prev_stall;
    logic [9:0]  prev_addr, exp_a;
    logic [47:0] prev_data;

    function automatic logic [47:0] exp_row(input int r);
        logic [9:0] a0, a1, a2;
        a0 = m_db + 10'(3 * r);
        a1 = a0 + 10'd1;
        a2 = a0 + 10'd2;
        return {mem[a2], mem[a1], mem[a0]};
    endfunction

    function automatic logic full_val(input int c, input int fmode, input int flo, input int fhi);
        case (fmode)
            1:       return (c >= flo) && (c <= fhi);
            2:       return $urandom_range(0, 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            rel = cyc_cnt - start_cyc;
            if (rd_en) begin
                exp_a = m_db + 10'(rd_idx);
                check_eq("rd_addr", rd_addr, exp_a);
                check_eq("rd_in_stall", wr_en & full, 0);
                check_eq("rd_overrun", rd_idx < m_rc * 3, 1);
                if (first_rd < 0) first_rd = rel;
                last_rd = rel;
                rd_idx++;
            end
            if (prev_stall) begin
                check_eq("wr_en_hold", wr_en, 1);
                check_eq("wr_addr_hold", wr_addr, prev_addr);
                check_eq("wr_data_hold", wr_data, prev_data);
            end
            if (wr_en && !full) begin
                exp_a = m_ib + 10'(wr_idx);
                check_eq("wr_addr", wr_addr, exp_a);
                check_eq("wr_data", wr_data, exp_row(wr_idx));
                acc_rel.push_back(rel);
                last_acc_addr = wr_addr;
                wr_idx++;
            end
            if (done && !done_seen) begin
                done_seen = 1'b1;
                done_rel  = rel;
                check_eq("busy_at_done", busy, 0);
                check_eq("rows_at_done", wr_idx, m_rc);
            end
            prev_stall = wr_en && full;
            prev_addr  = wr_addr;
            prev_data  = wr_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic run_xfer(input logic [9:0] db, input logic [9:0] ib, input int rc,
                            input int fmode, input int flo, input int fhi, input int rs_rel);
        m_db = db; m_ib = ib; m_rc = rc;
        rd_idx = 0; wr_idx = 0; first_rd = -1; last_rd = -1; done_rel = -1;
        done_seen = 1'b0;
        acc_rel.delete();
        @(posedge clk); #1;
        start_cyc = cyc_cnt;
        dma_base  = db;
        imem_base = ib;
        row_cnt   = 10'(rc);
        start     = 1'b1;
        full      = full_val(0, fmode, flo, fhi);
        mon_en    = 1'b1;
        for (int c = 1; c < 300 && !done_seen; c++) begin
            @(posedge clk); #1;
            start    = (c == rs_rel);
            dma_base = start ? ~db : db;
            row_cnt  = start ? 10'd7 : 10'(rc);
            full     = full_val(c, fmode, flo, fhi);
        end
        check_eq("xfer_done", done_seen, 1);
        @(posedge clk); #1;
        full   = 1'b0;
        start  = 1'b0;
        mon_en = 1'b0;
        check_eq("rd_total", rd_idx, rc * 3);
        check_eq("wr_total", wr_idx, rc);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_rd_en"}, rd_en, 0);
        check_eq({tag, "_rd_addr"}, rd_addr, 0);
        check_eq({tag, "_wr_en"}, wr_en, 0);
        check_eq({tag, "_wr_addr"}, wr_addr, 0);
        check_eq({tag, "_wr_data"}, wr_data, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);

        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
`ifdef NN_LOADER_PERF_EN
        check_eq("reset_stall_cnt", stall_cnt, 0);
`endif
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // basic timing
        run_xfer(10'h010, 10'h020, 2, 0, 0, 0, -1);
        check_eq("basic_first_rd", first_rd, 1);
        check_eq("basic_last_rd", last_rd, 6);
        check_eq("basic_acc_cnt", acc_rel.size(), 2);
        if (acc_rel.size() == 2) begin
            check_eq("basic_wr0_cycle", acc_rel[0], 5);
            check_eq("basic_wr1_cycle", acc_rel[1], 8);
        end
        check_eq("basic_done_cycle", done_rel, 9);

        // backpressure window on the first row
        run_xfer(10'h010, 10'h020, 2, 1, 5, 9, -1);
        check_eq("bp_acc_cnt", acc_rel.size(), 2);
        if (acc_rel.size() == 2) begin
            check_eq("bp_wr0_cycle", acc_rel[0], 10);
            check_eq("bp_wr1_cycle", acc_rel[1], 13);
        end
        check_eq("bp_done_cycle", done_rel, 14);

        // address wrap
        run_xfer(10'h3FE, 10'h3FF, 2, 0, 0, 0, -1);
        check_eq("wrap_last_row_addr", last_acc_addr, 10'h000);

        // zero rows
        run_xfer(10'h055, 10'h066, 0, 0, 0, 0, -1);
        check_eq("zero_done_cycle", done_rel, 1);

        // start while busy is ignored
        run_xfer(10'h080, 10'h200, 4, 0, 0, 0, 3);

        // reset in the middle of row 2 of 4
        @(posedge clk); #1;
        dma_base = 10'h100; imem_base = 10'h040; row_cnt = 10'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("midrst_no_done", done, 0);
        end
        run_xfer(10'h100, 10'h040, 4, 0, 0, 0, -1);

`ifdef NN_LOADER_PERF_EN
        run_xfer(10'h010, 10'h020, 2, 1, 5, 11, -1);
        check_eq("perf_stall_cnt", stall_cnt, 7);
        run_xfer(10'h030, 10'h020, 1, 0, 0, 0, -1);
        check_eq("perf_stall_clear", stall_cnt, 0);
`endif

        // randomized transfers against the memory model
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
            run_xfer(10'($urandom), 10'($urandom), $urandom_range(1, 6),
                     $urandom_range(0, 2), $urandom_range(2, 8), $urandom_range(8, 16), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
